// File: rtl/add_issue_ctrl.sv
// Issue controller for a registered adder/NOT stage: queues operations, issues them
// only when the 2-entry result buffer is guaranteed room, and returns results in order.
module add_issue_ctrl #(
    parameter int N     = 32,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    input  logic         in_cin,
    input  logic         in_sel,
    output logic [N-1:0] op_a,
    output logic [N-1:0] op_b,
    output logic         op_cin,
    output logic         op_sel,
    input  logic [N-1:0] add_sum,
    input  logic         add_cout,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_sum,
    output logic         out_cout,
    output logic         busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         cin;
        logic         sel;
    } op_t;

    op_t             q_mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   q_count;

    logic [N:0]      res_mem [2];
    logic            res_wr;
    logic            res_rd;
    logic [1:0]      res_count;

    logic            inflight;
    logic            push;
    logic            issue;
    logic            res_pop;
    logic [2:0]      res_occ;
    op_t             head;

    assign in_ready  = rst_n && (q_count < CW'(DEPTH));
    assign push      = in_valid && in_ready;
    assign out_valid = (res_count != 2'd0);
    assign res_pop   = out_valid && out_ready;

    // Results that will still occupy the buffer next cycle; issue only if one slot stays free.
    assign res_occ = {1'b0, res_count} + {2'b00, inflight} - {2'b00, res_pop};
    assign issue   = (q_count != '0) && (res_occ < 3'd2);

    always_comb begin
        head = '0;
        if (q_count != '0) begin
            head = q_mem[rd_ptr];
        end
    end

    assign op_a   = head.a;
    assign op_b   = head.b;
    assign op_cin = head.cin;
    assign op_sel = head.sel;

    assign {out_cout, out_sum} = res_mem[res_rd];
    assign busy = (q_count != '0) || inflight || (res_count != 2'd0);

    always_ff @(posedge clk) begin
        if (push) begin
            q_mem[wr_ptr] <= op_t'{a: in_a, b: in_b, cin: in_cin, sel: in_sel};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            q_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (issue) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, issue})
                2'b10:   q_count <= q_count + CW'(1);
                2'b01:   q_count <= q_count - CW'(1);
                default: q_count <= q_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (inflight) begin
            res_mem[res_wr] <= {add_cout, add_sum};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight  <= 1'b0;
            res_wr    <= 1'b0;
            res_rd    <= 1'b0;
            res_count <= 2'd0;
        end else begin
            inflight <= issue;
            if (inflight) begin
                res_wr <= ~res_wr;
            end
            if (res_pop) begin
                res_rd <= ~res_rd;
            end
            case ({inflight, res_pop})
                2'b10:   res_count <= res_count + 2'd1;
                2'b01:   res_count <= res_count - 2'd1;
                default: res_count <= res_count;
            endcase
        end
    end

endmodule

// File: tb/tb_add_issue_ctrl.sv
// Self-checking bench for add_issue_ctrl: models the downstream adder stage and
// checks every emitted result against a queue of results computed at accept time.
module tb_add_issue_ctrl;

    localparam int N     = 32;
    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] in_a = '0;
    logic [N-1:0] in_b = '0;
    logic         in_cin = 1'b0;
    logic         in_sel = 1'b0;
    logic [N-1:0] op_a;
    logic [N-1:0] op_b;
    logic         op_cin;
    logic         op_sel;
    logic [N-1:0] add_sum;
    logic         add_cout;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [N-1:0] out_sum;
    logic         out_cout;
    logic         busy;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    logic [N:0] exp_q [$];
    logic [N:0] recv_q [$];
    int         pop_cycles [$];
    logic       hold_prev = 1'b0;
    logic [N:0] hold_val = '0;

    add_issue_ctrl #(.N(N), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sel(in_sel),
        .op_a(op_a), .op_b(op_b), .op_cin(op_cin), .op_sel(op_sel),
        .add_sum(add_sum), .add_cout(add_cout),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    // Downstream registered adder/NOT stage the controller drives.
    always @(posedge clk) begin
        if (op_sel) {add_cout, add_sum} <= {1'b0, ~op_a};
        else        {add_cout, add_sum} <= {1'b0, op_a} + {1'b0, op_b} + (N+1)'(op_cin);
    end

    function automatic logic [N:0] ref_result(input logic [N-1:0] a, input logic [N-1:0] b,
                                              input logic cin, input logic sel);
        if (sel) return {1'b0, ~a};
        return {1'b0, a} + {1'b0, b} + (N+1)'(cin);
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Scoreboard: checks every result leaving the block, holds, and records accepts.
    always @(negedge clk) begin
        if (rst_n) begin
            if (hold_prev) begin
                checkOutput("hold_valid", 64'(out_valid), 64'd1);
                checkOutput("hold_data", 64'({out_cout, out_sum}), 64'(hold_val));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) checkOutput("pending_result", 64'(exp_q.size() > 0), 64'd1);
                else checkOutput("result_order", 64'({out_cout, out_sum}), 64'(exp_q.pop_front()));
                recv_q.push_back({out_cout, out_sum});
                pop_cycles.push_back(cycle);
            end
            if (in_valid && in_ready) exp_q.push_back(ref_result(in_a, in_b, in_cin, in_sel));
            hold_prev = out_valid && !out_ready;
            hold_val  = {out_cout, out_sum};
        end else begin
            hold_prev = 1'b0;
        end
    end

    // Called at posedge+1; returns at posedge+1 of the accepting edge.
    task automatic applyStimulus(input logic [N-1:0] a, input logic [N-1:0] b,
                                 input logic cin, input logic sel);
        bit accepted = 0;
        in_a = a; in_b = b; in_cin = cin; in_sel = sel; in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin accepted = 1; break; end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (!accepted) checkOutput("accept_timeout", 64'(accepted), 64'd1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        checkOutput("drain_done", 64'(busy), 64'd0);
        checkOutput("all_results_out", 64'(exp_q.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        int lat;
        logic [N-1:0] ra, rb;
        logic rc, rs;

        #2;
        checkOutput("reset_in_ready", 64'(in_ready), 64'd0);
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_op_a", 64'(op_a), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_hold_in_ready", 64'(in_ready), 64'd0);
        rst_n = 1'b1;
        #1;
        checkOutput("post_reset_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;

        $display("[TB] single add latency");
        out_ready = 1'b1;
        applyStimulus(32'h0000_0005, 32'h0000_0003, 1'b1, 1'b0);
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (out_valid) begin lat = i; break; end
        end
        checkOutput("single_add_latency", 64'(lat), 64'd3);
        checkOutput("single_add_result", 64'({out_cout, out_sum}), 64'h0_0000_0009);
        @(posedge clk); #1;
        wait_idle();

        $display("[TB] carry and NOT ordering");
        recv_q.delete();
        applyStimulus(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        applyStimulus(32'h0F0F_0F0F, $urandom, 1'($urandom), 1'b1);
        wait_idle();
        checkOutput("carry_not_count", 64'(recv_q.size()), 64'd2);
        if (recv_q.size() == 2) begin
            checkOutput("carry_result", 64'(recv_q[0]), 64'h1_0000_0000);
            checkOutput("not_result", 64'(recv_q[1]), 64'h0_F0F0_F0F0);
        end

        $display("[TB] backpressure");
        recv_q.delete();
        out_ready = 1'b0;
        for (int k = 0; k < 6; k++) applyStimulus($urandom, $urandom, 1'($urandom), 1'($urandom));
        repeat (4) @(posedge clk);
        #1;
        checkOutput("bp_in_ready_low", 64'(in_ready), 64'd0);
        checkOutput("bp_out_valid", 64'(out_valid), 64'd1);
        checkOutput("bp_busy", 64'(busy), 64'd1);
        checkOutput("bp_accepted", 64'(exp_q.size()), 64'd6);
        in_a = $urandom; in_b = $urandom; in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("bp_seventh_blocked", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        wait_idle();
        checkOutput("bp_all_out", 64'(recv_q.size()), 64'd6);

        $display("[TB] streaming");
        pop_cycles.delete();
        for (int k = 0; k < 16; k++) applyStimulus($urandom, $urandom, 1'($urandom), 1'($urandom));
        wait_idle();
        checkOutput("stream_count", 64'(pop_cycles.size()), 64'd16);
        if (pop_cycles.size() == 16)
            checkOutput("stream_rate", 64'(pop_cycles[15] - pop_cycles[0]), 64'd15);

        $display("[TB] reset mid-flight");
        out_ready = 1'b0;
        for (int k = 0; k < 6; k++) applyStimulus($urandom, $urandom, 1'($urandom), 1'($urandom));
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkOutput("pre_reset_busy", 64'(busy), 64'd1);
        checkOutput("pre_reset_out_valid", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        checkOutput("mid_reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("mid_reset_busy", 64'(busy), 64'd0);
        checkOutput("mid_reset_in_ready", 64'(in_ready), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        recv_q.delete();
        @(posedge clk); #1;
        ra = $urandom; rb = $urandom; rc = 1'($urandom); rs = 1'b0;
        applyStimulus(ra, rb, rc, rs);
        wait_idle();
        repeat (5) @(posedge clk);
        #1;
        checkOutput("post_reset_count", 64'(recv_q.size()), 64'd1);
        if (recv_q.size() >= 1)
            checkOutput("post_reset_result", 64'(recv_q[0]), 64'(ref_result(ra, rb, rc, rs)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
